// File: rtl/i2s_audio_pkg.sv
// i2s_audio_pkg: shared state/sample types and constant helpers for the I2S audio path
package i2s_audio_pkg;
  localparam int unsigned SAMPLE_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } sample_pair_t;
  function automatic longint unsigned acc_inc(input longint unsigned sample_hz, input longint unsigned slot_bits);
    return 4 * sample_hz * slot_bits;
  endfunction
  function automatic int unsigned cnt_w(input int unsigned slot_bits);
    return $clog2(2 * slot_bits);
  endfunction
endpackage

// File: rtl/i2s_frac_tick.sv
// i2s_frac_tick: fractional-N phase accumulator emitting INC/CLK_HZ ticks per clk
module i2s_frac_tick #(
  parameter longint unsigned CLK_HZ = 32000000,
  parameter longint unsigned INC    = 3072000,
  parameter int unsigned     ACC_W  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic tick_o
);
  localparam logic [ACC_W:0] INC_W = (ACC_W+1)'(INC);
  localparam logic [ACC_W:0] CLK_W = (ACC_W+1)'(CLK_HZ);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  // one extra bit on the sum keeps the compare exact; wrap subtracts CLK_HZ in the same cycle
  always_comb begin
    sum    = {1'b0, acc_q} + INC_W;
    tick_o = run_i && (sum >= CLK_W);
    acc_d  = !run_i ? '0 : tick_o ? ACC_W'(sum - CLK_W) : sum[ACC_W-1:0];
  end
  // accumulator register, held at zero while stopped
  always_ff @(posedge clk) acc_q <= reset ? '0 : acc_d;
endmodule

// File: rtl/i2s_audio_ctrl.sv
// i2s_audio_ctrl: Philips I2S DAC sequencer with fractional bclk and one-deep sample buffer (option: I2S_AUDIO_STATS_EN)
module i2s_audio_ctrl
  import i2s_audio_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 32000000,
  parameter int unsigned SAMPLE_HZ = 48000,
  parameter int unsigned SLOT_BITS = 16,
  parameter int unsigned ACC_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SLOT_BITS-1:0] in_l,
  input  logic [SLOT_BITS-1:0] in_r,
  output logic                 running,
  output logic                 frame_strobe,
  output logic                 underrun,
  output logic                 i2s_bclk,
  output logic                 i2s_lrck,
  output logic                 i2s_din,
`ifdef I2S_AUDIO_STATS_EN
  output logic [15:0]          underrun_cnt,
  output logic                 in_level,
`endif
  output logic                 pa_en
);
  localparam int unsigned   FW    = 2 * SLOT_BITS;
  localparam int unsigned   CW    = cnt_w(SLOT_BITS);
  localparam logic [CW-1:0] LAST  = CW'(FW - 1);
  localparam logic [CW-1:0] LR_LO = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] LR_HI = CW'(FW - 2);
  state_t          state_q, state_d;
  logic            bclk_q, bclk_d, lrck_q, lrck_d, hold_full_q, hold_full_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d, next_cnt;
  logic [FW-1:0]   shift_q, shift_d, last_q, last_d, hold_q, hold_d, frame;
  logic            tick, fall, wrap, stop_now, load_now, accept, idle;
  i2s_frac_tick #(
    .CLK_HZ(CLK_HZ),
    .INC   (acc_inc(SAMPLE_HZ, SLOT_BITS)),
    .ACC_W (ACC_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .run_i (running),
    .tick_o(tick)
  );
  // enable wins over stopping; a stop only lands on the edge that finishes the last slot bit
  always_comb state_d = enable ? RUN : (state_q == IDLE || stop_now) ? IDLE : STOPPING;
  // falling-edge bit/lrck/shifter updates, frame load and the holding-buffer handshake
  always_comb begin
    fall        = tick && bclk_q;
    wrap        = bit_cnt_q == LAST;
    stop_now    = fall && wrap && state_q == STOPPING && !enable;
    load_now    = fall && wrap && !stop_now;
    idle        = state_q == IDLE || stop_now;
    next_cnt    = wrap ? '0 : bit_cnt_q + 1'b1;
    frame       = hold_full_q ? hold_q : last_q;
    in_ready    = !hold_full_q || load_now;
    accept      = in_valid && in_ready;
    bclk_d      = !idle && (bclk_q ^ tick);
    bit_cnt_d   = idle ? LAST : fall ? next_cnt : bit_cnt_q;
    lrck_d      = !idle && (fall ? (next_cnt >= LR_LO && next_cnt <= LR_HI) : lrck_q);
    shift_d     = idle ? '0 : load_now ? frame : fall ? shift_q << 1 : shift_q;
    last_d      = load_now ? frame : last_q;
    hold_d      = accept ? {in_l, in_r} : hold_q;
    hold_full_d = accept || (hold_full_q && !load_now);
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      last_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
  assign running      = state_q != IDLE;
  assign pa_en        = running;
  assign frame_strobe = load_now;
  assign underrun     = load_now && !hold_full_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_din      = shift_q[FW-1];
`ifdef I2S_AUDIO_STATS_EN
  logic [15:0] underrun_cnt_q;
  // saturating underrun counter
  always_ff @(posedge clk) underrun_cnt_q <= reset ? '0 : (underrun && underrun_cnt_q != '1) ? underrun_cnt_q + 1'b1 : underrun_cnt_q;
  assign underrun_cnt = underrun_cnt_q;
  assign in_level     = hold_full_q;
`endif
endmodule

// File: tb/tb_i2s_audio_ctrl.sv
// tb_i2s_audio_ctrl: scoreboard bench; frames expected at load time are checked when they finish serialising
module tb_i2s_audio_ctrl;
  import i2s_audio_pkg::*;
  logic clk = 0, reset = 1, enable = 0, in_valid = 0;
  logic [15:0] in_l = 0, in_r = 0;
  logic in_ready, running, frame_strobe, underrun, i2s_bclk, i2s_lrck, i2s_din, pa_en;
`ifdef I2S_AUDIO_STATS_EN
  logic [15:0] underrun_cnt;
  logic in_level;
`endif
  int n_cmp = 0, n_bad = 0;
  sample_pair_t exp_q[$];
  sample_pair_t m_hold, m_last, f_exp, f_pop;
  logic m_full, bclk_p, lr_p, seen_edge, watch_run = 0, run_dropped = 0;
  logic [31:0] sr;
  int n0, n1, since, frames_done = 0, strobes = 0, coincide = 0;

  always #5 clk = ~clk;

  i2s_audio_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .running(running), .frame_strobe(frame_strobe), .underrun(underrun),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_din(i2s_din),
`ifdef I2S_AUDIO_STATS_EN
    .underrun_cnt(underrun_cnt), .in_level(in_level),
`endif
    .pa_en(pa_en)
  );

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // buffer model pushes expected frames on loads; serial decoder pops and compares
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_full = 0; m_last = '0; m_hold = '0;
      n0 = -1; n1 = 0; lr_p = 0; sr = 0; since = 0; seen_edge = 0;
    end else begin
      chk("in_ready", in_ready, !m_full || frame_strobe);
      if (frame_strobe) begin
        chk("underrun_at_load", underrun, !m_full);
        f_exp = m_full ? m_hold : m_last;
        m_last = f_exp;
        exp_q.push_back(f_exp);
        m_full = 0;
        strobes++;
        if (in_valid && in_ready) coincide++;
      end else chk("underrun_no_load", underrun, 0);
      if (in_valid && in_ready) begin m_hold = {in_l, in_r}; m_full = 1; end
      if (!running) begin n0 = -1; n1 = 0; lr_p = 0; end
      if (i2s_bclk && !bclk_p) begin
        sr = {sr[30:0], i2s_din};
        if (i2s_lrck) n1++; else n0++;
        if (!i2s_lrck && lr_p) begin
          chk("lrck_low_bits", n0, 16);
          chk("lrck_high_bits", n1, 16);
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL frame: got %h, expected none pending", sr);
          end else begin
            f_pop = exp_q.pop_front();
            chk("frame", sr, f_pop);
          end
          frames_done++;
          n0 = 0; n1 = 0;
        end
        lr_p = i2s_lrck;
      end
      if (running) begin
        since++;
        if (i2s_bclk != bclk_p) begin
          if (seen_edge) begin
            n_cmp++;
            if (since < 10 || since > 11) begin
              n_bad++;
              $display("FAIL bclk_half_period: got %0d clks, expected 10..11", since);
            end
          end
          seen_edge = 1; since = 0;
        end
      end else begin seen_edge = 0; since = 0; end
      if (watch_run && !running) run_dropped = 1;
    end
    bclk_p = i2s_bclk;
  end

  task automatic wait_running(input logic lvl, input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (running != lvl && k < 2000);
    if (running != lvl) begin n_cmp++; n_bad++; $display("FAIL %s: running stuck at %0b, expected %0b", name, running, lvl); end
  endtask

  task automatic wait_bit(input int b);
    int k = 0;
    do begin @(negedge clk); k++; end while (dut.bit_cnt_q != b && k < 2000);
    if (dut.bit_cnt_q != b) begin n_cmp++; n_bad++; $display("FAIL wait_bit: bit_cnt %0d, expected %0d", dut.bit_cnt_q, b); end
  endtask

  task automatic wait_strobe(output logic u);
    int k = 0;
    do begin @(negedge clk); k++; end while (!frame_strobe && k < 2000);
    u = underrun;
    if (!frame_strobe) begin n_cmp++; n_bad++; $display("FAIL wait_strobe: frame_strobe 0, expected 1"); end
  endtask

  task automatic wait_ready();
    int k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 2000);
    if (!in_ready) begin n_cmp++; n_bad++; $display("FAIL wait_ready: in_ready 0, expected 1"); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, s0, f0;
    logic prev, u;
    logic exp_u[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_running", running, 0);
    chk("rst_frame_strobe", frame_strobe, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_bclk", i2s_bclk, 0);
    chk("rst_lrck", i2s_lrck, 0);
    chk("rst_din", i2s_din, 0);
    chk("rst_pa_en", pa_en, 0);
    // continuous A5F0/0F3C stream; bclk rate over 10000 clks
    @(posedge clk); #2 in_l = 16'hA5F0; in_r = 16'h0F3C; in_valid = 1;
    @(posedge clk); #2 enable = 1;
    wait_running(1, "start");
    chk("run_pa_en", pa_en, 1);
    edges = 0; s0 = strobes; f0 = frames_done; prev = i2s_bclk;
    repeat (10000) begin
      @(negedge clk);
      if (i2s_bclk != prev) edges++;
      prev = i2s_bclk;
    end
    @(posedge clk);
    chk("bclk_edges_10k", edges, 960);
    chk("frame_strobes_10k", strobes - s0, 15);
    chk("frames_decoded_10k", frames_done - f0, 14);
    chk("load_accept_same_cycle", coincide, strobes);
    // single 1234/8001 pair then starve the buffer
    wait_ready();
    @(posedge clk); #2 in_valid = 0;
    in_l = 16'h1234; in_r = 16'h8001; in_valid = 1;
    wait_ready();
    @(posedge clk); #2 in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(u);
      chk("underrun_seq", u, exp_u[i]);
      @(posedge clk); #1;
`ifdef I2S_AUDIO_STATS_EN
      chk("underrun_cnt", underrun_cnt, i);
      chk("in_level", in_level, 0);
`endif
    end
    // stop requested at bit 5 completes after bit 31
    wait_bit(5);
    @(posedge clk); #2 enable = 0;
    f0 = frames_done;
    wait_running(0, "stop");
    @(posedge clk);
    chk("stop_frames_completed", frames_done - f0, 1);
    chk("stop_queue_empty", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    chk("stop_bclk", i2s_bclk, 0);
    chk("stop_lrck", i2s_lrck, 0);
    chk("stop_din", i2s_din, 0);
    chk("stop_pa_en", pa_en, 0);
    chk("stop_running", running, 0);
    // stop request withdrawn at bit 20 keeps frames contiguous
    @(posedge clk); #2 enable = 1;
    wait_running(1, "restart");
    @(posedge clk); #2 watch_run = 1;
    wait_bit(5);
    @(posedge clk); #2 enable = 0;
    wait_bit(20);
    @(posedge clk); #2 enable = 1;
    f0 = frames_done;
    begin
      int k = 0;
      while (frames_done < f0 + 2 && k < 3000) begin @(posedge clk); k++; end
    end
    chk("restart_frames", frames_done - f0, 2);
    chk("restart_no_drop", run_dropped, 0);
    watch_run = 0;
    // reset mid-frame
    wait_bit(10);
    @(posedge clk); #2 reset = 1; enable = 0;
    @(posedge clk); #1;
    chk("mid_rst_bclk", i2s_bclk, 0);
    chk("mid_rst_lrck", i2s_lrck, 0);
    chk("mid_rst_din", i2s_din, 0);
    chk("mid_rst_pa_en", pa_en, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_strobe", frame_strobe, 0);
    chk("mid_rst_underrun", underrun, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_state", dut.state_q, IDLE);
    @(negedge clk); #1 reset = 0;
    repeat (5) @(posedge clk);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
